// File: rtl/wb_dmem_responder_if.sv
// Wishbone B4 pipelined bus bundle between a data initiator and wb_dmem_responder.
// Signal names keep the responder-side _i/_o orientation of the bus pins.
interface wb_dmem_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_stall_o;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
    );
endinterface

// File: rtl/wb_dmem_responder.sv
// Wishbone B4 pipelined responder over a single-port 32-bit RAM, one access in flight.
// Optional write-protected low region: define WB_DMEM_ROM_REGION_EN (size ROM_WORDS).
module wb_dmem_responder #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned ROM_WORDS   = 0
) (
    input logic      clk_i,
    input logic      reset_i,
    wb_dmem_if.slave wb
);

    localparam logic [32:0] SPAN      = 33'd1 << (ADDR_WIDTH + 2);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    if (WAIT_STATES > 7 || ROM_WORDS > (1 << ADDR_WIDTH)) begin : g_param_check
        $error("wb_dmem_responder: WAIT_STATES or ROM_WORDS out of range");
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state_r, state_s;
    logic [2:0]              cnt_r, cnt_s;
    logic                    accept_s, enter_resp_s, write_en_s;
    logic                    err_s, rom_err_s, idle_s;
    logic                    we_r;
    logic [31:0]             adr_r, dat_r;
    logic [3:0]              sel_r;
    logic                    acc_we_s;
    logic [31:0]             acc_adr_s, acc_dat_s;
    logic [3:0]              acc_sel_s;
    logic [ADDR_WIDTH-1:0]   idx_s;
    logic                    ack_r, err_r;
    logic [31:0]             rdata_r;
    logic [31:0]             mem_r [(1 << ADDR_WIDTH)];

    // With zero wait states the RAM access happens on the accept edge itself,
    // so the access fields come straight from the bus while idle.
    assign idle_s    = (state_r == ST_IDLE);
    assign acc_we_s  = idle_s ? wb.wb_we_i  : we_r;
    assign acc_adr_s = idle_s ? wb.wb_adr_i : adr_r;
    assign acc_dat_s = idle_s ? wb.wb_dat_i : dat_r;
    assign acc_sel_s = idle_s ? wb.wb_sel_i : sel_r;
    assign idx_s     = ADDR_WIDTH'((acc_adr_s - BASE_ADDR) >> 2);

`ifdef WB_DMEM_ROM_REGION_EN
    assign rom_err_s = acc_we_s & (32'(idx_s) < 32'(ROM_WORDS));
`else
    assign rom_err_s = 1'b0;
`endif

    assign err_s = (acc_adr_s[1:0] != 2'b00)
                 | (acc_adr_s < BASE_ADDR)
                 | ({1'b0, acc_adr_s} >= ({1'b0, BASE_ADDR} + SPAN))
                 | rom_err_s;

    assign write_en_s = enter_resp_s & acc_we_s & ~err_s & reset_i;

    // Next-state and wait counter; a dropped cyc in WAIT abandons the access
    always_comb begin
        state_s      = state_r;
        cnt_s        = cnt_r;
        accept_s     = 1'b0;
        enter_resp_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (wb.wb_cyc_i && wb.wb_stb_i) begin
                    accept_s = 1'b1;
                    if (WAIT_STATES > 0) begin
                        state_s = ST_WAIT;
                        cnt_s   = WAIT_LOAD;
                    end else begin
                        state_s      = ST_RESP;
                        enter_resp_s = 1'b1;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!wb.wb_cyc_i) begin
                    state_s = ST_IDLE;
                end else if (cnt_r == 3'd0) begin
                    state_s      = ST_RESP;
                    enter_resp_s = 1'b1;
                end else begin
                    cnt_s = cnt_r - 3'd1;
                end
            end
            ST_RESP: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State and wait counter registers
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_r <= ST_IDLE;
            cnt_r   <= 3'd0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Request capture on accept
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            we_r  <= 1'b0;
            adr_r <= 32'h0;
            dat_r <= 32'h0;
            sel_r <= 4'h0;
        end else if (accept_s) begin
            we_r  <= wb.wb_we_i;
            adr_r <= wb.wb_adr_i;
            dat_r <= wb.wb_dat_i;
            sel_r <= wb.wb_sel_i;
        end
    end

    // Response registers, loaded on the edge entering RESP and cleared otherwise
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0;
        end else if (enter_resp_s) begin
            ack_r   <= ~err_s;
            err_r   <= err_s;
            rdata_r <= (!acc_we_s && !err_s) ? mem_r[idx_s] : 32'h0;
        end else begin
            ack_r   <= 1'b0;
            err_r   <= 1'b0;
            rdata_r <= 32'h0;
        end
    end

    // Byte-lane RAM write; contents survive reset
    always_ff @(posedge clk_i) begin
        if (write_en_s) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel_s[b]) begin
                    mem_r[idx_s][8*b +: 8] <= acc_dat_s[8*b +: 8];
                end
            end
        end
    end

    // A response is withheld if the initiator has already left the cycle
    assign wb.wb_stall_o = ~idle_s;
    assign wb.wb_ack_o   = ack_r & wb.wb_cyc_i;
    assign wb.wb_err_o   = err_r & wb.wb_cyc_i;
    assign wb.wb_dat_o   = (ack_r & wb.wb_cyc_i) ? rdata_r : 32'h0;

endmodule

// File: tb/tb_wb_dmem_responder.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) driven through their bus interfaces.
module tb_wb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  cyc_v, stb_v, we_v;
    logic [31:0] adr_v [3];
    logic [31:0] dat_v [3];
    logic [3:0]  sel_v [3];
    logic [2:0]  ack_w, err_w, stall_w;
    logic [31:0] dato_w [3];
    int          checks = 0;
    int          errors = 0;
    int          ws_tab [3] = '{1, 0, 3};

    always #5 clk = ~clk;

    wb_dmem_if ifc0 ();
    wb_dmem_if ifc1 ();
    wb_dmem_if ifc2 ();

    wb_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h1000_0000), .WAIT_STATES(1), .ROM_WORDS(4))
        dut0 (.clk_i(clk), .reset_i(rst_n), .wb(ifc0));
    wb_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(0), .ROM_WORDS(0))
        dut1 (.clk_i(clk), .reset_i(rst_n), .wb(ifc1));
    wb_dmem_responder #(.ADDR_WIDTH(12), .BASE_ADDR(32'h0000_0000), .WAIT_STATES(3), .ROM_WORDS(0))
        dut2 (.clk_i(clk), .reset_i(rst_n), .wb(ifc2));

    assign ifc0.wb_cyc_i = cyc_v[0];  assign ifc1.wb_cyc_i = cyc_v[1];  assign ifc2.wb_cyc_i = cyc_v[2];
    assign ifc0.wb_stb_i = stb_v[0];  assign ifc1.wb_stb_i = stb_v[1];  assign ifc2.wb_stb_i = stb_v[2];
    assign ifc0.wb_we_i  = we_v[0];   assign ifc1.wb_we_i  = we_v[1];   assign ifc2.wb_we_i  = we_v[2];
    assign ifc0.wb_adr_i = adr_v[0];  assign ifc1.wb_adr_i = adr_v[1];  assign ifc2.wb_adr_i = adr_v[2];
    assign ifc0.wb_dat_i = dat_v[0];  assign ifc1.wb_dat_i = dat_v[1];  assign ifc2.wb_dat_i = dat_v[2];
    assign ifc0.wb_sel_i = sel_v[0];  assign ifc1.wb_sel_i = sel_v[1];  assign ifc2.wb_sel_i = sel_v[2];
    assign ack_w   = {ifc2.wb_ack_o,   ifc1.wb_ack_o,   ifc0.wb_ack_o};
    assign err_w   = {ifc2.wb_err_o,   ifc1.wb_err_o,   ifc0.wb_err_o};
    assign stall_w = {ifc2.wb_stall_o, ifc1.wb_stall_o, ifc0.wb_stall_o};
    assign dato_w[0] = ifc0.wb_dat_o;
    assign dato_w[1] = ifc1.wb_dat_o;
    assign dato_w[2] = ifc2.wb_dat_o;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One complete transaction on responder k, checking latency, termination, data and stall.
    task automatic xfer(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input logic exp_err, input logic [31:0] exp_dat,
                        input string tag);
        int          lat;
        int          stalls;
        logic        got_ack, got_err, extra;
        logic [31:0] got_dat;
        lat = 0; stalls = 0; got_ack = 1'b0; got_err = 1'b0; got_dat = 32'h0;
        @(negedge clk);
        cyc_v[k] = 1'b1; stb_v[k] = 1'b1; we_v[k] = w;
        adr_v[k] = a; dat_v[k] = d; sel_v[k] = s;
        @(posedge clk);
        for (int c = 1; c <= 16 && lat == 0; c++) begin
            @(negedge clk);
            stb_v[k] = 1'b0;
            if (stall_w[k]) stalls++;
            if (ack_w[k] || err_w[k]) begin
                lat = c; got_ack = ack_w[k]; got_err = err_w[k]; got_dat = dato_w[k];
            end
        end
        @(negedge clk);
        cyc_v[k] = 1'b0;
        extra = ack_w[k] | err_w[k];
        if (stall_w[k]) stalls++;
        chk({tag, "_lat"},   32'(lat),     32'(ws_tab[k] + 1));
        chk({tag, "_ack"},   32'(got_ack), 32'(!exp_err));
        chk({tag, "_err"},   32'(got_err), 32'(exp_err));
        chk({tag, "_dat"},   got_dat,      exp_dat);
        chk({tag, "_stall"}, 32'(stalls),  32'(ws_tab[k] + 1));
        chk({tag, "_extra"}, 32'(extra),   32'd0);
    endtask

    initial begin
        int          accepts;
        int          acks;
        int          resp;
        logic        stall_seen;
        logic [31:0] rom_rd;

        rst_n = 1'b0;
        cyc_v = 3'b000; stb_v = 3'b000; we_v = 3'b000;
        for (int k = 0; k < 3; k++) begin
            adr_v[k] = 32'h0; dat_v[k] = 32'h0; sel_v[k] = 4'h0;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst%0d_stall", k), 32'(stall_w[k]), 32'd0);
            chk($sformatf("rst%0d_ack", k),   32'(ack_w[k]),   32'd0);
            chk($sformatf("rst%0d_err", k),   32'(err_w[k]),   32'd0);
            chk($sformatf("rst%0d_dat", k),   dato_w[k],       32'h0);
        end
        rst_n = 1'b1;

        // WAIT_STATES=1, base 0x1000_0000
        xfer(0, 1'b1, 32'h1000_0010, 32'hDEAD_BEEF, 4'hF, 1'b0, 32'h0,         "wr_full");
        xfer(0, 1'b0, 32'h1000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAD_BEEF, "rd_full");
        xfer(0, 1'b1, 32'h1000_0010, 32'h00AA_0000, 4'h4, 1'b0, 32'h0,         "wr_lane2");
        xfer(0, 1'b0, 32'h1000_0010, 32'h0,         4'h1, 1'b0, 32'hDEAA_BEEF, "rd_lane2");
        xfer(0, 1'b1, 32'h1000_0010, 32'hFFFF_FFFF, 4'h0, 1'b0, 32'h0,         "wr_sel0");
        xfer(0, 1'b0, 32'h1000_0010, 32'h0,         4'hF, 1'b0, 32'hDEAA_BEEF, "rd_sel0");
        xfer(0, 1'b0, 32'h1000_0013, 32'h0,         4'hF, 1'b1, 32'h0,         "rd_misal");
        xfer(0, 1'b0, 32'h0FFF_FFFC, 32'h0,         4'hF, 1'b1, 32'h0,         "rd_below");
        xfer(0, 1'b1, 32'h1000_3FFC, 32'h0BAD_F00D, 4'hF, 1'b0, 32'h0,         "wr_last");
        xfer(0, 1'b0, 32'h1000_3FFC, 32'h0,         4'hF, 1'b0, 32'h0BAD_F00D, "rd_last");
        xfer(0, 1'b0, 32'h1000_4000, 32'h0,         4'hF, 1'b1, 32'h0,         "rd_above");

        // WAIT_STATES=0: out-of-range write leaves RAM alone
        xfer(1, 1'b1, 32'h0000_0000, 32'h1122_3344, 4'hF, 1'b0, 32'h0,         "w0_wr0");
        xfer(1, 1'b1, 32'h0000_4000, 32'h5566_7788, 4'hF, 1'b1, 32'h0,         "w0_wr_oor");
        xfer(1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 1'b0, 32'h1122_3344, "w0_rd0");

        // WAIT_STATES=0: stb held for six edges
        accepts = 0; acks = 0;
        @(negedge clk);
        cyc_v[1] = 1'b1; stb_v[1] = 1'b1; we_v[1] = 1'b0; adr_v[1] = 32'h0000_0000;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) @(negedge clk);
            if (!stall_w[1]) accepts++;
            if (ack_w[1]) acks++;
        end
        @(negedge clk);
        stb_v[1] = 1'b0;
        if (ack_w[1]) acks++;
        @(negedge clk);
        cyc_v[1] = 1'b0;
        if (ack_w[1]) acks++;
        chk("b2b_accepts", 32'(accepts), 32'd3);
        chk("b2b_acks",    32'(acks),    32'd3);

        // WAIT_STATES=3: cyc dropped in the second wait cycle
        xfer(2, 1'b1, 32'h0000_0040, 32'hA5A5_A5A5, 4'hF, 1'b0, 32'h0, "w3_wr");
        resp = 0; stall_seen = 1'b0;
        @(negedge clk);
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b1;
        adr_v[2] = 32'h0000_0040; dat_v[2] = 32'h1234_5678; sel_v[2] = 4'hF;
        @(negedge clk);
        stb_v[2] = 1'b0;
        if (ack_w[2] || err_w[2]) resp++;
        @(negedge clk);
        cyc_v[2] = 1'b0;
        if (ack_w[2] || err_w[2]) resp++;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) stall_seen = stall_w[2];
            if (ack_w[2] || err_w[2]) resp++;
        end
        chk("abort_resp",  32'(resp),       32'd0);
        chk("abort_stall", 32'(stall_seen), 32'd0);
        xfer(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5, "abort_rd");

        // WAIT_STATES=3: reset pulsed mid-wait
        resp = 0;
        @(negedge clk);
        cyc_v[2] = 1'b1; stb_v[2] = 1'b1; we_v[2] = 1'b1;
        adr_v[2] = 32'h0000_0040; dat_v[2] = 32'h1234_5678; sel_v[2] = 4'hF;
        @(negedge clk);
        stb_v[2] = 1'b0;
        chk("rstmid_pre_stall", 32'(stall_w[2]), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstmid_stall", 32'(stall_w[2]), 32'd0);
        chk("rstmid_ack",   32'(ack_w[2] | err_w[2]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (ack_w[2] || err_w[2]) resp++;
        end
        cyc_v[2] = 1'b0;
        chk("rstmid_resp", 32'(resp), 32'd0);
        xfer(2, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 1'b0, 32'hA5A5_A5A5, "rstmid_rd");

`ifdef WB_DMEM_ROM_REGION_EN
        // ROM_WORDS=4 on the first responder: word 3 protected, word 4 writable
        xfer(0, 1'b1, 32'h1000_000C, 32'hCAFE_F00D, 4'hF, 1'b1, 32'h0, "rom_wr3");
        @(negedge clk);
        cyc_v[0] = 1'b1; stb_v[0] = 1'b1; we_v[0] = 1'b0; adr_v[0] = 32'h1000_000C;
        rom_rd = 32'h0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            stb_v[0] = 1'b0;
            if (ack_w[0]) rom_rd = dato_w[0];
        end
        cyc_v[0] = 1'b0;
        checks++;
        assert (rom_rd !== 32'hCAFE_F00D) else begin
            errors++;
            $error("FAIL rom_rd3 observed=%h expected=not cafef00d", rom_rd);
        end
        xfer(0, 1'b1, 32'h1000_0010, 32'h7777_7777, 4'hF, 1'b0, 32'h0,         "rom_wr4");
        xfer(0, 1'b0, 32'h1000_0010, 32'h0,         4'hF, 1'b0, 32'h7777_7777, "rom_rd4");
`else
        rom_rd = 32'h0;
        xfer(0, 1'b1, 32'h1000_000C, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0,         "noprot_wr3");
        xfer(0, 1'b0, 32'h1000_000C, 32'h0,         4'hF, 1'b0, 32'hCAFE_F00D, "noprot_rd3");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
